// File: rtl/hazard_controller_if.sv
// Hazard controller bundle: pipeline register indices and enables in, stall/flush/forward
// selects out. The pipeline side is the master, the controller the slave.
interface hazard_controller_if;
  logic [4:0] Rs1D;
  logic [4:0] Rs2D;
  logic [4:0] Rs1E;
  logic [4:0] Rs2E;
  logic [4:0] RdE;
  logic [4:0] RdM;
  logic [4:0] RdW;
  logic       RegWriteM;
  logic       RegWriteW;
  logic [1:0] ResultSrcE;
  logic       PCSrcE;
  logic       MdvStartE;
  logic [1:0] ForwardAE;
  logic [1:0] ForwardBE;
  logic       StallF;
  logic       StallD;
  logic       StallE;
  logic       FlushD;
  logic       FlushE;
  logic       FlushM;
  logic       MdvBusy;
  logic       MdvDoneE;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW, ResultSrcE, PCSrcE,
           MdvStartE,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, MdvBusy,
           MdvDoneE
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW, ResultSrcE, PCSrcE,
           MdvStartE,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, MdvBusy,
           MdvDoneE
  );
endinterface

// File: rtl/hazard_controller.sv
// Execute-stage forwarding, load-use stall, branch flush and multi-cycle mul/div sequencing.
// The mul/div sequencer is built only when HAZARD_MULDIV_EN is defined.
module hazard_controller #(
  parameter int unsigned MDV_LATENCY = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  hazard_controller_if.slave hz_io
);

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic wr_m,
                                         input logic [4:0] rd_m, input logic wr_w,
                                         input logic [4:0] rd_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (wr_m && (rd_m == rs) && (rs != 5'd0)) begin
      sel = 2'b10;
    end else if (wr_w && (rd_w == rs) && (rs != 5'd0)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  logic lw_stall;
  logic mdv_stall;
  logic mdv_busy;
  logic mdv_done;

  assign lw_stall = (hz_io.ResultSrcE == 2'b01) && (hz_io.RdE != 5'd0) &&
                    ((hz_io.Rs1D == hz_io.RdE) || (hz_io.Rs2D == hz_io.RdE));

`ifdef HAZARD_MULDIV_EN
  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [5:0] CntInit = 6'(MDV_LATENCY - 2);

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A branch resolving alongside the start kills the operation before it begins.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (hz_io.MdvStartE && !hz_io.PCSrcE) begin
          state_d = StBusy;
          cnt_d   = CntInit;
        end
      end
      StBusy: begin
        if (cnt_q == 6'd0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mdv_stall = ((state_q == StIdle) && hz_io.MdvStartE && !hz_io.PCSrcE) ||
                (state_q == StBusy);
    mdv_busy  = (state_q == StBusy) || ((state_q == StIdle) && mdv_stall);
    mdv_done  = (state_q == StDone);
  end
`else
  logic [8:0] unused_mdv;
  assign unused_mdv = {clk, reset_n, hz_io.MdvStartE, 6'(MDV_LATENCY)};
  assign mdv_stall  = 1'b0;
  assign mdv_busy   = 1'b0;
  assign mdv_done   = 1'b0;
`endif

  assign hz_io.ForwardAE = fwd_sel(hz_io.Rs1E, hz_io.RegWriteM, hz_io.RdM,
                                   hz_io.RegWriteW, hz_io.RdW);
  assign hz_io.ForwardBE = fwd_sel(hz_io.Rs2E, hz_io.RegWriteM, hz_io.RdM,
                                   hz_io.RegWriteW, hz_io.RdW);
  assign hz_io.StallF    = lw_stall || mdv_stall;
  assign hz_io.StallD    = lw_stall || mdv_stall;
  assign hz_io.StallE    = mdv_stall;
  assign hz_io.FlushM    = mdv_stall;
  assign hz_io.FlushD    = hz_io.PCSrcE;
  // Never bubble E while it holds an in-flight multi-cycle operation.
  assign hz_io.FlushE    = (lw_stall || hz_io.PCSrcE) && !mdv_stall;
  assign hz_io.MdvBusy   = mdv_busy;
  assign hz_io.MdvDoneE  = mdv_done;

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Central hazard and sequencing controller for the five-stage pipeline's execute datapath. It selects the execute-stage operand forwarding paths, detects load-use hazards, and flushes on taken branches and jumps. It also sequences an optional multi-cycle multiply/divide operation by freezing the front of the pipeline until the operation completes. It sits beside the decode, execute and memory stages and drives their stall and flush controls and the two execute forwarding multiplexers.

## Interface
- MDV_LATENCY, 32: number of busy cycles for a multi-cycle operation (legal range 2..64)
- clk  input  1  pipeline clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- Rs1D, Rs2D  input  5 each  decode-stage source registers
- Rs1E, Rs2E, RdE  input  5 each  execute-stage source and destination registers
- RdM, RdW  input  5 each  memory-stage and writeback-stage destination registers
- RegWriteM, RegWriteW  input  1 each  register write enables for the memory and writeback stages
- ResultSrcE  input  2  execute-stage result select; 2'b01 marks a load
- PCSrcE  input  1  taken branch or jump resolved in execute
- MdvStartE  input  1  execute-stage instruction is a multi-cycle operation
- ForwardAE, ForwardBE  output  2 each  forwarding select: 00 register file, 01 ResultW, 10 ALUResultM
- StallF, StallD, StallE  output  1 each  hold the PC, the decode pipeline register and the execute pipeline register
- FlushD, FlushE  output  1 each  insert a bubble into the decode or execute pipeline register
- FlushM  output  1  insert a bubble into the memory pipeline register
- MdvBusy  output  1  multi-cycle operation in progress
- MdvDoneE  output  1  one-cycle strobe: multi-cycle result valid and captured into M this cycle

## Operation
- Forwarding, computed combinationally, ForwardAE shown; ForwardBE is the same with Rs2E:
  - 10 if RegWriteM && RdM==Rs1E && Rs1E!=0
  - otherwise 01 if RegWriteW && RdW==Rs1E && Rs1E!=0
  - otherwise 00
  - The memory stage has priority over writeback.
- Load-use: lwStall = (ResultSrcE==2'b01) && RdE!=0 && (Rs1D==RdE || Rs2D==RdE).
- mdvStall = (state==IDLE && MdvStartE && !PCSrcE) || state==BUSY.
- StallF = StallD = lwStall || mdvStall.
- StallE = FlushM = mdvStall.
- FlushD = PCSrcE.
- FlushE = (lwStall || PCSrcE) && !mdvStall. The execute bubble is never allowed to destroy an in-flight multi-cycle operation.
- FSM states are IDLE, BUSY and DONE; a 6-bit counter `cnt` tracks the busy time.
  - IDLE: if MdvStartE && !PCSrcE, go to BUSY and load cnt = MDV_LATENCY-2.
  - BUSY: decrement cnt each cycle; when cnt==0, go to DONE.
  - DONE: MdvDoneE=1 and all stalls are released, so the instruction advances to M. MdvStartE is ignored. The next state is always IDLE.
- MdvBusy = (state==BUSY) || (state==IDLE && mdvStall).
- Simultaneous events:
  - PCSrcE and MdvStartE both high in IDLE: PCSrcE wins, the FSM stays IDLE and FlushD/FlushE assert.
  - lwStall during BUSY: it is absorbed by the mdv stall, with no FlushE.
  - MdvStartE held high while in DONE: it does not retrigger.

## Timing
- Forwarding, stall and flush outputs are combinational from the inputs and the current state, with no added latency.
- A multi-cycle operation asserts StallE for exactly MDV_LATENCY cycles: the start cycle plus MDV_LATENCY-1 BUSY cycles. This is followed by one DONE cycle.
- Reset (asynchronous assert): state=IDLE, cnt=0, MdvBusy=0, MdvDoneE=0. With inputs at 0, every output is 0.
- Reset asserted mid-operation aborts the operation immediately. The following cycle after release is IDLE with no DONE strobe.

## Configuration
- HAZARD_MULDIV_EN defined: the FSM, the counter and the mdv stall logic are present, as described above.
- HAZARD_MULDIV_EN undefined: no FSM or counter is built. MdvStartE is ignored. mdvStall=0, MdvBusy=0, MdvDoneE=0, and StallE=FlushM=0. Forwarding, load-use and branch flush logic are unchanged.

## Test plan
- Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10. With RdM=6 -> ForwardAE=01. With Rs1E=0 -> ForwardAE=00.
- ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle. Next cycle ResultSrcE=00 -> all stalls 0.
- PCSrcE=1 -> FlushD=FlushE=1 and StallF=0. PCSrcE and MdvStartE both 1 -> MdvBusy stays 0.
- MDV_LATENCY=4, MdvStartE=1 held -> StallE=1 for cycles 0..3, MdvDoneE=1 in cycle 4, IDLE in cycle 5.
- Same as above, plus lwStall conditions in cycle 2 -> FlushE stays 0 and StallD=1.
- reset_n pulsed low in cycle 2 of a busy operation -> MdvBusy=0 asynchronously, and no MdvDoneE is ever generated.
